// File: rtl/aq_spsram_ctrl_pkg.sv
// Shared types and constants for the 128x8 single-port SRAM controller.
package aq_spsram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int           RSP_DEPTH_DEF  = 4;
    localparam logic         CEN_IDLE       = 1'b1;
    localparam logic         GWEN_IDLE      = 1'b1;
    localparam logic [7:0]   WEN_ALL_OFF    = 8'hFF;
    localparam int           INIT_LAST_ADDR = 127;

endpackage

// File: rtl/aq_spsram_rsp_fifo.sv
// Read-response FIFO: DEPTH x DW, registered storage, head visible while non-empty.
module aq_spsram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/aq_spsram_128x8_ctrl.sv
// Initiator-side controller for the 128x8 SP-SRAM macro: init sweep, registered
// pin stage, S2 capture of Q into an in-order response FIFO with read credits.
module aq_spsram_128x8_ctrl
    import aq_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    WE_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter int                    RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [WE_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam int                    OW      = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(INIT_LAST_ADDR);
    localparam logic [WE_WIDTH-1:0]   WEN_OFF = WE_WIDTH'(WEN_ALL_OFF);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    init_done_q, init_done_d;
    logic [OW-1:0]           outst_q, outst_d;
    logic                    rd_s2_q, rd_s2_d;
    logic                    cen_q, cen_d, gwen_q, gwen_d;
    logic [WE_WIDTH-1:0]     wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;

    logic pop, acc, acc_rd, fifo_empty;

    // Credit check looks through a same-cycle pop so a full pipe can refill at once.
    assign pop     = rsp_vld && rsp_rdy;
    assign req_rdy = init_done_q && ((outst_q - OW'(pop)) < OW'(RSP_DEPTH));
    assign acc     = req_vld && req_rdy;
    assign acc_rd  = acc && !req_wr;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q | (state_q == ST_RUN);
        outst_d     = outst_q + OW'(acc_rd) - OW'(pop);
        rd_s2_d     = !cen_q && gwen_q;
        cen_d       = CEN_IDLE;
        gwen_d      = GWEN_IDLE;
        wen_d       = WEN_OFF;
        a_d         = a_q;
        dat_d       = dat_q;
        if (state_q == ST_INIT) begin
            cen_d      = 1'b0;
            gwen_d     = 1'b0;
            wen_d      = '0;
            a_d        = init_cnt_q;
            dat_d      = INIT_VAL;
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == LAST_A) state_d = ST_RUN;
        end else if (acc) begin
            cen_d = 1'b0;
            a_d   = req_addr;
            if (req_wr) begin
                gwen_d = 1'b0;
                wen_d  = ~req_wmask;
                dat_d  = req_wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            outst_q     <= '0;
            rd_s2_q     <= 1'b0;
            cen_q       <= CEN_IDLE;
            gwen_q      <= GWEN_IDLE;
            wen_q       <= WEN_OFF;
            a_q         <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            outst_q     <= outst_d;
            rd_s2_q     <= rd_s2_d;
            cen_q       <= cen_d;
            gwen_q      <= gwen_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            dat_q       <= dat_d;
        end
    end

    aq_spsram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .push      (rd_s2_q),
        .push_data (sram_q),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (rsp_rdata)
    );

    assign rsp_vld   = !fifo_empty;
    assign init_done = init_done_q;
    assign sram_a    = a_q;
    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_d    = dat_q;

endmodule

// File: tb/tb_aq_spsram_128x8_ctrl.sv
// Bench for aq_spsram_128x8_ctrl: behavioural macro, memory/response reference model,
// per-cycle pin/handshake checks, directed cases then randomized traffic.
module tb_aq_spsram_128x8_ctrl;
    localparam logic [7:0] INIT = 8'h00;

    logic       forever_cpuclk = 1'b0;
    logic       cpurst_b = 1'b0;
    logic       req_vld = 1'b0, req_rdy, req_wr = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0, req_wmask = '0;
    logic       rsp_vld, rsp_rdy = 1'b0;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic [6:0] sram_a;
    logic       sram_cen, sram_gwen;
    logic [7:0] sram_wen, sram_d;
    logic [7:0] sram_q = '0;

    aq_spsram_128x8_ctrl dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural macro: samples pins on the edge, Q valid the following cycle.
    logic [7:0] mem_m [128];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem_m[sram_a] <= (mem_m[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem_m[sram_a];
        end
    end

    typedef struct { logic [7:0] d; int c; } exp_t;
    exp_t       exp_q [$];
    logic [7:0] ref_mem [128];
    int         nvec = 0, nerr = 0, cyc_n = 0;
    logic       p_acc = 1'b0, p_wr = 1'b0;
    logic [6:0] p_addr = '0, pin_a = '0;
    logic [7:0] p_wd = '0, p_wm = '0, pin_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        p_acc = 1'b0;
        pin_a = '0;
        pin_d = '0;
        cyc_n = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = INIT;
    endtask

    // Called at a negedge; asserts reset, checks idle state, releases at a later negedge.
    task automatic do_reset();
        req_vld = 1'b0;
        cpurst_b = 1'b0;
        #1;
        chk("rst_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {2'b11, 8'hFF, 7'h00, 8'h00});
        chk("rst_vld", {rsp_vld, req_rdy, init_done}, 3'b000);
        @(negedge forever_cpuclk);
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        model_reset();
    endtask

    // One cycle, entered at a negedge: drive, check against the model, advance.
    task automatic cyc(input logic vld, input logic wr, input logic [6:0] addr,
                       input logic [7:0] wd, input logic [7:0] wm, input logic rr,
                       output logic acc);
        logic [24:0] ep;
        logic        ev, mpop;
        exp_t        e;
        req_vld = vld; req_wr = wr; req_addr = addr;
        req_wdata = wd; req_wmask = wm; rsp_rdy = rr;
        #1;
        if (cyc_n >= 1 && cyc_n <= 128) begin
            pin_a = 7'(cyc_n - 1);
            pin_d = INIT;
            ep = {2'b00, 8'h00, pin_a, pin_d};
        end else if (p_acc && p_wr) begin
            pin_a = p_addr;
            pin_d = p_wd;
            ep = {2'b00, ~p_wm, pin_a, pin_d};
        end else if (p_acc) begin
            pin_a = p_addr;
            ep = {2'b01, 8'hFF, pin_a, pin_d};
        end else begin
            ep = {2'b11, 8'hFF, pin_a, pin_d};
        end
        chk("pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, ep);
        chk("init_done", init_done, cyc_n >= 129);
        ev = (exp_q.size() > 0) && (exp_q[0].c + 3 <= cyc_n);
        chk("rsp_vld", rsp_vld, ev);
        mpop = ev && rr;
        chk("req_rdy", req_rdy, (cyc_n >= 129) && ((exp_q.size() - int'(mpop)) < 4));
        if (rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) chk("rsp_extra", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.d);
            end
        end
        acc = vld && req_rdy;
        p_acc = acc; p_wr = wr; p_addr = addr; p_wd = wd; p_wm = wm;
        if (acc) begin
            if (wr) ref_mem[addr] = (ref_mem[addr] & ~wm) | (wd & wm);
            else    exp_q.push_back('{ref_mem[addr], cyc_n});
        end
        @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        cyc_n++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'h0, 8'h0, 8'h0, 1'b1, a);
    endtask

    initial begin
        logic a;
        int   n;
        @(negedge forever_cpuclk);
        do_reset();
        // Init sweep, with requests offered that must not be taken.
        for (int i = 0; i < 131; i++)
            cyc(1'($urandom_range(0, 1)), 1'b0, 7'($urandom), 8'h0, 8'h0, 1'b1, a);

        // Write then read the same address back-to-back.
        cyc(1'b1, 1'b1, 7'h05, 8'hA5, 8'hFF, 1'b1, a);
        cyc(1'b1, 1'b0, 7'h05, 8'h00, 8'h00, 1'b1, a);
        idle(5);

        // Partial bit mask.
        cyc(1'b1, 1'b1, 7'h10, 8'hFF, 8'hFF, 1'b1, a);
        cyc(1'b1, 1'b1, 7'h10, 8'h00, 8'h0F, 1'b1, a);
        cyc(1'b1, 1'b0, 7'h10, 8'h00, 8'h00, 1'b1, a);
        idle(5);

        // Pattern in 0..15.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 7'(i), 8'(i * 7 + 3), 8'hFF, 1'b1, a);
        idle(3);

        // Stalled consumer: credits cap accepts at the FIFO depth.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 7'(i), 8'h0, 8'h0, 1'b0, a);
            n += int'(a);
        end
        chk("stall_acc", n, 4);
        idle(8);

        // Streaming reads with consumer always ready.
        n = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 7'(i), 8'h0, 8'h0, 1'b1, a);
            n += int'(a);
        end
        chk("stream_acc", n, 16);
        idle(6);

        // Randomized traffic on a narrow address window for frequent hits.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 31)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), a);
        idle(8);

        // Reset with reads in flight; stale data must not reappear and contents re-init.
        cyc(1'b1, 1'b1, 7'h03, 8'h5A, 8'hFF, 1'b1, a);
        cyc(1'b1, 1'b0, 7'h03, 8'h00, 8'h00, 1'b0, a);
        cyc(1'b1, 1'b0, 7'h05, 8'h00, 8'h00, 1'b0, a);
        do_reset();
        idle(133);
        cyc(1'b1, 1'b0, 7'h03, 8'h00, 8'h00, 1'b1, a);
        cyc(1'b1, 1'b0, 7'h05, 8'h00, 8'h00, 1'b1, a);
        idle(6);
        chk("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
